hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the in-order pipeline. Tracks every in-flight destination write

---
 rtl/hazard_scoreboard_pkg.sv | 30 +++
 rtl/hazard_src_match.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_pkg
//  Description : Shared types and constants for the hazard/forwarding scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Entry fields are sized for the widest supported build (32 regs x 8 bits, DEPTH <= 15)
    localparam int c_SB_RD_W     = 8;
    localparam int c_SB_LAT_W    = 4;

    localparam int c_FWD_REGFILE = 0;
    localparam int c_ALU_LAT     = 1;
    localparam int c_LOAD_LAT    = 2;

    typedef struct packed {
        logic                  valid;
        logic [c_SB_RD_W-1:0]  rd;
        logic [c_SB_LAT_W-1:0] lat;
    } sb_entry_t;

    function automatic int clampLat(input int lat, input int depth);
        if (lat < c_ALU_LAT) return c_ALU_LAT;
        if (lat > depth - 1) return depth - 1;
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_src_match
//  Description : Compares one source register against every scoreboard entry;
//                reports the match vector and the youngest matching stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH          = 3,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_W          = $clog2(DEPTH),
    parameter int MIN_STAGE      = 0
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_src,
    input  logic                      i_used,
    input  sb_entry_t [DEPTH-1:0]     i_entries,
    output logic [DEPTH-1:0]          o_matchVec,
    output logic [FWD_W-1:0]          o_youngest
);

    always_comb begin
        o_matchVec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_matchVec[k] = i_used && i_entries[k].valid && (i_src != '0) &&
                            (i_entries[k].rd == c_SB_RD_W'(i_src));
        end
    end

    // Scan oldest to youngest so the lowest matching stage is left standing
    always_comb begin
        o_youngest = FWD_W'(c_FWD_REGFILE);
        for (int k = DEPTH - 1; k >= MIN_STAGE; k--) begin
            if (o_matchVec[k]) o_youngest = FWD_W'(k);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Parametrised forwarding / load-use stall / redirect-flush unit.
//                Optional perf counters enabled by defining HAZARD_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int DEPTH          = 3,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PERF_W         = 32,
    parameter int LAT_W          = $clog2(DEPTH + 1),
    parameter int FWD_W          = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [NUM_SRC-1:0]                id_rs_used,
    input  logic [REG_ADDR_WIDTH-1:0]         id_rd,
    input  logic                              id_reg_write,
    input  logic [LAT_W-1:0]                  id_lat,
    input  logic                              ex_redirect,
    output logic                              stall_f,
    output logic                              stall_d,
    output logic                              flush_d,
    output logic                              flush_e,
    output logic [NUM_SRC*FWD_W-1:0]          ex_fwd_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]                 perf_stall_cnt,
    output logic [PERF_W-1:0]                 perf_flush_cnt
`endif
);

    sb_entry_t [DEPTH-1:0]             r_entries;
    logic [NUM_SRC*REG_ADDR_WIDTH-1:0] r_exRs;
    logic [NUM_SRC-1:0]                r_exUsed;

    logic                              w_luStall;
    logic                              w_issue;
    sb_entry_t                         w_newEntry;
    logic [NUM_SRC*FWD_W-1:0]          w_fwdSel;
    logic [DEPTH-1:0]                  w_idMatch        [NUM_SRC];
    logic [DEPTH-1:0]                  w_unusedExMatch  [NUM_SRC];
    logic [FWD_W-1:0]                  w_unusedIdYoung  [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .DEPTH(DEPTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .FWD_W(FWD_W), .MIN_STAGE(1)
        ) u_exMatch (
            .i_src      (r_exRs[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .i_used     (r_exUsed[i]),
            .i_entries  (r_entries),
            .o_matchVec (w_unusedExMatch[i]),
            .o_youngest (w_fwdSel[i*FWD_W +: FWD_W])
        );

        hazard_src_match #(
            .DEPTH(DEPTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .FWD_W(FWD_W), .MIN_STAGE(0)
        ) u_idMatch (
            .i_src      (id_rs[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .i_used     (id_rs_used[i]),
            .i_entries  (r_entries),
            .o_matchVec (w_idMatch[i]),
            .o_youngest (w_unusedIdYoung[i])
        );
    end

    // Clamped latency never exceeds DEPTH-1, so the last two stages can never satisfy s+1<lat
    always_comb begin
        w_luStall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (w_idMatch[i][s] && (s + 1 < int'(r_entries[s].lat))) w_luStall = 1'b1;
            end
        end
        w_luStall = w_luStall && id_valid;
    end

    assign w_issue          = id_valid && !w_luStall && !ex_redirect;
    assign w_newEntry.valid = w_issue && id_reg_write && (id_rd != '0);
    assign w_newEntry.rd    = c_SB_RD_W'(id_rd);
    assign w_newEntry.lat   = c_SB_LAT_W'(clampLat(int'(id_lat), DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entries <= '0;
            r_exRs    <= '0;
            r_exUsed  <= '0;
        end else begin
            r_entries <= {r_entries[DEPTH-2:0], w_newEntry};
            r_exRs    <= w_issue ? id_rs : '0;
            r_exUsed  <= w_issue ? id_rs_used : '0;
        end
    end

    assign stall_f    = !reset && w_luStall && !ex_redirect;
    assign stall_d    = !reset && w_luStall && !ex_redirect;
    assign flush_d    = !reset && ex_redirect;
    assign flush_e    = !reset && (w_luStall || ex_redirect);
    assign ex_fwd_sel = reset ? '0 : w_fwdSel;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stallCnt;
    logic [PERF_W-1:0] r_flushCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_luStall && !ex_redirect && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + PERF_W'(1);
            if (ex_redirect && (r_flushCnt != '1))               r_flushCnt <= r_flushCnt + PERF_W'(1);
        end
    end

    assign perf_stall_cnt = reset ? '0 : r_stallCnt;
    assign perf_flush_cnt = reset ? '0 : r_flushCnt;
`else
    localparam int c_unusedPerfW = PERF_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Scoreboard bench for hazard_scoreboard in two configurations
//                (DEPTH=3/NUM_SRC=2 and DEPTH=5/NUM_SRC=3); perf checks under HAZARD_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int RW       = 5;
    localparam int PW       = 32;
    localparam int N_RANDOM = 3000;
    localparam int N_DIR    = 22;

    typedef struct { logic [3:0] ctrl; logic [15:0] fwd; longint st; longint fl; } exp_t;
    typedef struct { bit v; bit wr; int rd; int lat; int rs[3]; bit used[3]; } inst_t;
    typedef struct { bit rst; bit vld; int rs0; int rs1; int used; int rd; bit wr; int lat;
                     bit red; logic [3:0] ctrl; int f0; int f1; } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit done [2];

    // ctrl = {stall_f, stall_d, flush_d, flush_e}; f0/f1 = expected ex_fwd_sel per operand
    row_t dirTab [N_DIR] = '{
        '{0,1,0,0,0,5,1,c_ALU_LAT, 0,4'b0000,0,0},  // add x5
        '{0,1,5,0,3,6,1,c_ALU_LAT, 0,4'b0000,0,0},  // add x6,x5,x0
        '{0,0,0,0,0,0,0,0,         0,4'b0000,1,0},  // consumer in E forwards from stage 1
        '{0,1,0,0,0,5,1,c_LOAD_LAT,0,4'b0000,0,0},  // lw x5
        '{0,1,5,5,3,6,1,c_ALU_LAT, 0,4'b1101,0,0},  // add x6,x5,x5 -> load-use stall
        '{0,1,5,5,3,6,1,c_ALU_LAT, 0,4'b0000,0,0},  // held, released
        '{0,0,0,0,0,0,0,0,         0,4'b0000,2,2},  // forwards from stage 2
        '{0,1,0,0,0,0,1,c_LOAD_LAT,0,4'b0000,0,0},  // lw x0
        '{0,1,0,0,3,1,1,c_ALU_LAT, 0,4'b0000,0,0},  // use x0: no stall
        '{0,0,0,0,0,0,0,0,         0,4'b0000,0,0},
        '{0,1,0,0,0,7,1,c_ALU_LAT, 0,4'b0000,0,0},  // add x7 (older)
        '{0,1,0,0,0,7,1,c_ALU_LAT, 0,4'b0000,0,0},  // add x7 (younger)
        '{0,1,7,7,3,8,1,c_ALU_LAT, 0,4'b0000,0,0},
        '{0,0,0,0,0,0,0,0,         0,4'b0000,1,1},  // youngest producer wins
        '{0,1,0,0,0,5,1,c_LOAD_LAT,0,4'b0000,0,0},  // lw x5
        '{0,1,5,0,1,6,1,c_ALU_LAT, 1,4'b0011,0,0},  // load-use + redirect
        '{0,0,0,0,0,0,0,0,         0,4'b0000,0,0},
        '{0,1,0,0,0,5,1,c_LOAD_LAT,0,4'b0000,0,0},  // lw x5
        '{0,1,5,5,3,6,1,c_ALU_LAT, 0,4'b1101,0,0},  // stall
        '{1,1,5,5,3,6,1,c_ALU_LAT, 0,4'b0000,0,0},  // reset during stall
        '{0,1,5,5,3,6,1,c_ALU_LAT, 0,4'b0000,0,0},  // hazard discarded
        '{0,0,0,0,0,0,0,0,         0,4'b0000,0,0}
    };

    function automatic inst_t mkBubble();
        inst_t b;
        b.v = 0; b.wr = 0; b.rd = 0; b.lat = 0;
        for (int i = 0; i < 3; i++) begin b.rs[i] = 0; b.used[i] = 0; end
        return b;
    endfunction

    for (genvar c = 0; c < 2; c++) begin : g_cfg
        localparam int D  = (c == 0) ? 3 : 5;
        localparam int NS = (c == 0) ? 2 : 3;
        localparam int LW = $clog2(D + 1);
        localparam int FW = $clog2(D);

        logic              reset, id_valid, id_reg_write, ex_redirect;
        logic [NS*RW-1:0]  id_rs;
        logic [NS-1:0]     id_rs_used;
        logic [RW-1:0]     id_rd;
        logic [LW-1:0]     id_lat;
        logic              stall_f, stall_d, flush_d, flush_e;
        logic [NS*FW-1:0]  ex_fwd_sel;
`ifdef HAZARD_PERF_EN
        logic [PW-1:0]     perf_stall_cnt, perf_flush_cnt;
`endif

        hazard_scoreboard #(.NUM_SRC(NS), .DEPTH(D), .REG_ADDR_WIDTH(RW), .PERF_W(PW)) dut (
            .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
            .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat), .ex_redirect(ex_redirect),
            .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
            .ex_fwd_sel(ex_fwd_sel)
`ifdef HAZARD_PERF_EN
            , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
        );

        // Reference model: hist[k] is the instruction that is k cycles past Execute
        inst_t  hist [$];
        exp_t   expQ [$];
        longint mStall, mFlush;

        function automatic int effLat(int l);
            return (l < 1) ? 1 : ((l > D - 1) ? D - 1 : l);
        endfunction

        function automatic bit writes(int k, int r);
            return (r != 0) && hist[k].v && hist[k].wr && (hist[k].rd == r);
        endfunction

        task automatic applyCycle(input bit rst, input inst_t ins, input bit red,
                                  input bit hand, input logic [3:0] hCtrl, input logic [15:0] hFwd);
            exp_t  e;
            inst_t nxt;
            bit    lu;
            int    f;
            reset = rst; id_valid = ins.v; id_rd = RW'(ins.rd); id_reg_write = ins.wr;
            id_lat = LW'(ins.lat); ex_redirect = red;
            id_rs = '0; id_rs_used = '0;
            for (int i = 0; i < NS; i++) begin
                id_rs[i*RW +: RW] = RW'(ins.rs[i]);
                id_rs_used[i]     = ins.used[i];
            end
            lu = 0;
            e.ctrl = '0; e.fwd = '0; e.st = 0; e.fl = 0;
            if (rst) begin
                hist.delete();
                for (int k = 0; k < D; k++) hist.push_back(mkBubble());
                mStall = 0; mFlush = 0;
            end else begin
                if (ins.v)
                    for (int i = 0; i < NS; i++)
                        for (int s = 0; s <= D - 2; s++)
                            if (ins.used[i] && writes(s, ins.rs[i]) && (s + 1 < effLat(hist[s].lat))) lu = 1;
                for (int i = 0; i < NS; i++) begin
                    f = c_FWD_REGFILE;
                    for (int k = D - 1; k >= 1; k--)
                        if (hist[0].v && hist[0].used[i] && writes(k, hist[0].rs[i])) f = k;
                    e.fwd[i*FW +: FW] = FW'(f);
                end
                e.ctrl = {lu && !red, lu && !red, red, lu || red};
                e.st = mStall; e.fl = mFlush;
                if (lu && !red) mStall++;
                if (red) mFlush++;
                nxt = (ins.v && !lu && !red) ? ins : mkBubble();
                hist.push_front(nxt);
                void'(hist.pop_back());
            end
            if (hand) begin e.ctrl = hCtrl; e.fwd = hFwd; end
            expQ.push_back(e);
        endtask

        initial begin
            inst_t       ins;
            logic [15:0] hf;
            reset = 1; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
            id_reg_write = 0; id_lat = '0; ex_redirect = 0;
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                applyCycle(1, mkBubble(), 0, 0, '0, '0);
                @(posedge clk); #1;
            end
            for (int r = 0; r < N_DIR; r++) begin
                ins = mkBubble();
                ins.v = dirTab[r].vld; ins.rd = dirTab[r].rd; ins.wr = dirTab[r].wr; ins.lat = dirTab[r].lat;
                ins.rs[0] = dirTab[r].rs0; ins.rs[1] = dirTab[r].rs1;
                ins.used[0] = dirTab[r].used[0]; ins.used[1] = dirTab[r].used[1];
                hf = '0;
                hf[0 +: FW]  = FW'(dirTab[r].f0);
                hf[FW +: FW] = FW'(dirTab[r].f1);
                applyCycle(dirTab[r].rst, ins, dirTab[r].red, 1, dirTab[r].ctrl, hf);
                @(posedge clk); #1;
            end
            for (int n = 0; n < N_RANDOM; n++) begin
                ins.v   = ($urandom_range(0, 9) < 8);
                ins.rd  = int'($urandom_range(0, 3));
                ins.wr  = ($urandom_range(0, 4) != 0);
                ins.lat = int'($urandom_range(0, (1 << LW) - 1));
                for (int i = 0; i < 3; i++) begin
                    ins.rs[i]   = int'($urandom_range(0, 3));
                    ins.used[i] = $urandom_range(0, 1) != 0;
                end
                applyCycle($urandom_range(0, 49) == 0, ins, $urandom_range(0, 9) == 0, 0, '0, '0);
                @(posedge clk); #1;
            end
            repeat (2) @(negedge clk);
            vectors++;
            if (expQ.size() != 0) begin
                miscompares++;
                $display("FAIL drain cfg%0d: %0d expected responses left, want 0", c, expQ.size());
            end
            done[c] = 1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                vectors++;
                if ({stall_f, stall_d, flush_d, flush_e} !== e.ctrl) begin
                    miscompares++;
                    $display("FAIL ctrl cfg%0d t=%0t: got %b want %b", c, $time,
                             {stall_f, stall_d, flush_d, flush_e}, e.ctrl);
                end
                vectors++;
                if (16'(ex_fwd_sel) !== e.fwd) begin
                    miscompares++;
                    $display("FAIL fwd cfg%0d t=%0t: got %h want %h", c, $time, 16'(ex_fwd_sel), e.fwd);
                end
`ifdef HAZARD_PERF_EN
                vectors++;
                if (longint'(perf_stall_cnt) != e.st) begin
                    miscompares++;
                    $display("FAIL stall_cnt cfg%0d t=%0t: got %0d want %0d", c, $time, perf_stall_cnt, e.st);
                end
                vectors++;
                if (longint'(perf_flush_cnt) != e.fl) begin
                    miscompares++;
                    $display("FAIL flush_cnt cfg%0d t=%0t: got %0d want %0d", c, $time, perf_flush_cnt, e.fl);
                end
`endif
            end
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(done[0] && done[1]); t++) @(posedge clk);
        if (!(done[0] && done[1])) begin
            miscompares++;
            $display("FAIL timeout: done=%b%b want 11", done[1], done[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
